// File: rtl/approx_pkg.sv
// approx_pkg: shared types and helpers for the approximate-multiplier
// characterisation blocks.
//   state_t   : report FSM states (ACCUM, REPORT)
//   OP_W      : operand width of the multipliers under test
//   PROD_W    : product width
//   exact_mul : reference unsigned product, also used by the multiplier benches
package approx_pkg;

  localparam int OP_W   = 4;
  localparam int PROD_W = 8;

  typedef enum logic {
    ACCUM  = 1'b0,
    REPORT = 1'b1
  } state_t;

  function automatic logic [PROD_W-1:0] exact_mul(input logic [OP_W-1:0] x,
                                                  input logic [OP_W-1:0] y);
    return PROD_W'(x) * PROD_W'(y);
  endfunction

endpackage

// File: rtl/approx_ed_calc.sv
// approx_ed_calc: combinational error distance |a*b - approx|.
//   a, b   : operands (OP_W)
//   approx : product from the multiplier under test (PROD_W)
//   ed     : error distance (PROD_W), 0..255
module approx_ed_calc
  import approx_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  input  logic [PROD_W-1:0] approx,
  output logic [PROD_W-1:0] ed
);

  // One extra bit so the difference of two unsigned bytes never wraps;
  // the magnitude of a 9-bit value in -255..255 always fits in 8 bits.
  logic signed [PROD_W:0] diff;

  assign diff = $signed({1'b0, exact_mul(a, b)}) - $signed({1'b0, approx});
  assign ed   = diff[PROD_W] ? PROD_W'(-diff) : PROD_W'(diff);

endmodule

// File: rtl/approx_error_monitor.sv
// approx_error_monitor: per-window error statistics for approximate multipliers.
//   clk, rst        : clock, synchronous active-high reset
//   clear           : synchronous window abort (same effect as rst)
//   in_valid/ready  : sample handshake carrying a, b, approx
//   rpt_valid/ready : report handshake
//   rpt_sum_ed      : sum of error distances over the window
//   rpt_max_ed      : largest error distance in the window
//   rpt_err_cnt     : samples with nonzero error distance
module approx_error_monitor
  import approx_pkg::*;
#(
  parameter int WIN_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OP_W-1:0]       a,
  input  logic [OP_W-1:0]       b,
  input  logic [PROD_W-1:0]     approx,
  output logic                  rpt_valid,
  input  logic                  rpt_ready,
  output logic [WIN_LOG2+7:0]   rpt_sum_ed,
  output logic [PROD_W-1:0]     rpt_max_ed,
  output logic [WIN_LOG2:0]     rpt_err_cnt
);

  localparam int CNT_W = WIN_LOG2 + 1;
  localparam logic [CNT_W-1:0] WIN_LAST = {1'b0, {WIN_LOG2{1'b1}}};

  state_t              state, state_nxt;
  logic                win_full;
  logic [CNT_W-1:0]    in_cnt;
  logic [CNT_W-1:0]    acc_cnt;
  logic                s1_valid;
  logic [PROD_W-1:0]   s1_ed;
  logic [PROD_W-1:0]   ed;
  logic [WIN_LOG2+7:0] sum_ed;
  logic [PROD_W-1:0]   max_ed;
  logic [CNT_W-1:0]    err_cnt;
  logic                flush;
  logic                accept;
  logic                last_acc;
  logic                rpt_done;

  approx_ed_calc u_ed_calc (
    .a      (a),
    .b      (b),
    .approx (approx),
    .ed     (ed)
  );

  assign flush    = rst || clear;
  assign in_ready = (state == ACCUM) && !win_full;
  // clear outranks the input handshake: an offered sample is dropped.
  assign accept   = in_valid && in_ready && !clear;
  assign last_acc = s1_valid && (acc_cnt == WIN_LAST);
  assign rpt_done = (state == REPORT) && rpt_ready;

  always_ff @(posedge clk) begin
    if (flush) state <= ACCUM;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (last_acc)  state_nxt = REPORT;
      REPORT:  if (rpt_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (flush || rpt_done) begin
      win_full <= 1'b0;
      in_cnt   <= '0;
      acc_cnt  <= '0;
      s1_valid <= 1'b0;
      s1_ed    <= '0;
      sum_ed   <= '0;
      max_ed   <= '0;
      err_cnt  <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_ed  <= ed;
        in_cnt <= in_cnt + 1'b1;
        if (in_cnt == WIN_LAST) win_full <= 1'b1;
      end
      if (s1_valid) begin
        sum_ed  <= sum_ed + {{WIN_LOG2{1'b0}}, s1_ed};
        if (s1_ed > max_ed) max_ed <= s1_ed;
        err_cnt <= err_cnt + {{WIN_LOG2{1'b0}}, (s1_ed != '0)};
        acc_cnt <= acc_cnt + 1'b1;
      end
    end
  end

  assign rpt_valid   = (state == REPORT);
  assign rpt_sum_ed  = sum_ed;
  assign rpt_max_ed  = max_ed;
  assign rpt_err_cnt = err_cnt;

endmodule

// File: doc/approx_error_monitor.md
# approx_error_monitor

Downstream statistics stage for the 4x4 approximate multipliers. Each accepted sample carries the operands and the product the multiplier under test produced. The block forms the error distance against the exact product, and accumulates per-window sum, maximum and nonzero-error count. It then presents one report per window through a valid/ready handshake. It is used in both the exhaustive-sweep bench and on-chip characterisation.

## Interface
- WIN_LOG2, default 8: window length is 2^WIN_LOG2 samples. The legal range is 1..16; 8 covers the exhaustive 4x4 operand space.
- clk  input  1  clock; every register updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous window abort; zeroes all state.
- in_valid  input  1  sample present.
- in_ready  output  1  sample can be accepted.
- a  input  4  multiplicand.
- b  input  4  multiplier.
- approx  input  8  product produced by the multiplier under test.
- rpt_valid  output  1  window report present.
- rpt_ready  input  1  report consumed.
- rpt_sum_ed  output  WIN_LOG2+8  sum of error distances over the window.
- rpt_max_ed  output  8  largest error distance in the window.
- rpt_err_cnt  output  WIN_LOG2+1  number of samples whose error distance is nonzero.

## Operation
- Error distance: ED = |a*b − approx|.
  - The exact product is 8-bit unsigned.
  - The difference is formed at 9 bits signed, then the magnitude is taken. ED is in the range 0..255.
- Two states: ACCUM and REPORT.
- in_ready = (state==ACCUM) && !win_full.
  - win_full sets on the edge that accepts the 2^WIN_LOG2-th sample of the window.
  - Accepted-sample counter: WIN_LOG2+1 bits.
- Stage 1, on accept: register ED and s1_valid.
- Stage 2, on s1_valid:
  - sum += ED (no overflow is possible at the stated widths).
  - max = max(max, ED).
  - err_cnt += (ED != 0).
  - Accumulated counter increments.
- ACCUM→REPORT on the edge where the accumulated count reaches 2^WIN_LOG2.
- In REPORT:
  - rpt_valid=1 and the rpt_* outputs equal the accumulator registers, held stable.
  - in_ready=0.
- REPORT→ACCUM on the edge with rpt_valid && rpt_ready. The same edge zeroes the accumulators and counters and clears win_full.
- rpt_* outputs are undefined-free: they always equal the accumulators, but are meaningful only while rpt_valid=1.
- clear:
  - Zeroes the accumulators, counters, s1_valid and win_full, and forces ACCUM.
  - Takes priority over the input and report handshakes in the same cycle. A sample offered in that cycle is dropped.
  - A clear in REPORT discards the report.
- rst: same effect as clear.
- Reset values: in_ready=1 on the first cycle after reset; rpt_valid=0; rpt_sum_ed=0; rpt_max_ed=0; rpt_err_cnt=0.

## Timing
- The input handshake completes on an edge with in_valid && in_ready.
- Throughput: one sample per cycle in ACCUM, with no bubbles required.
- Latency, last sample to report:
  - Last sample accepted at edge E0, ED registered.
  - Accumulated and state=REPORT at E1.
  - rpt_valid=1 in the cycle after E1.
- in_ready is low from the cycle after E0 until the cycle after the report handshake edge.
- Minimum window period: 2^WIN_LOG2 + 2 cycles, with rpt_ready held high.
- in_valid gaps: the pipeline simply idles. s1_valid=0 means there is no accumulator update.
- rpt_ready held low: REPORT persists indefinitely and the outputs stay frozen.
- Reset in any state takes effect on the next edge; the pipeline contents are lost.

## Structure
- Package approx_pkg holds:
  - The state enum (ACCUM, REPORT).
  - OP_W=4 and PROD_W=8.
  - An exact_mul function shared with the multiplier benches.
- Sub-module approx_ed_calc: combinational; inputs a, b, approx; output ED[7:0]. It feeds stage 1.
- The top level holds the handshake, FSM, counters and accumulators.

## Test plan
- Test 1, exact multiplier:
  - Stimulus: WIN_LOG2=8; sweep all 256 (a,b) pairs back-to-back with approx=a*b.
  - Response: one report with sum=0, max=0, err_cnt=0; rpt_valid rises 2 cycles after the last accept.
- Test 2, constant offset:
  - Stimulus: 256-sample sweep with approx = a*b+1 clipped at 255 (225+1=226, no clip occurs).
  - Response: sum=256, max=1, err_cnt=256.
- Test 3, extreme error:
  - Stimulus: WIN_LOG2=1; samples (15,15,approx=0) and (0,0,approx=255).
  - Response: sum=480, max=255, err_cnt=2.
- Test 4, report backpressure:
  - Stimulus: hold rpt_ready=0 for 50 cycles after rpt_valid while in_valid stays 1.
  - Response: in_ready=0 and the rpt_* outputs are stable throughout. After the handshake, in_ready=1 next cycle and the next report reflects only new samples.
- Test 5, clear mid-window:
  - Stimulus: clear after 100 samples with nonzero error, and a clear coincident with an offered sample.
  - Response: the dropped sample is not counted. The next report covers exactly 256 post-clear samples.
- Test 6, reset and bubbles:
  - Stimulus: random in_valid gaps, plus rst asserted during REPORT.
  - Response: totals are unaffected by the gaps. After rst: rpt_valid=0, rpt_* outputs are 0, in_ready=1.
